// File: rtl/cyp_sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM ring-buffer arbiter: FSM encodings, command
// direction constants and default burst size.
package cyp_sdram_arbiter_pkg;

  localparam int DATA_W        = 16;
  localparam int DEF_BURST_LEN = 256;

  localparam logic SD_CMD_WR = 1'b1;
  localparam logic SD_CMD_RD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_DAT = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_DAT = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/cyp_sdram_arbiter_ring_ptr.sv
// Ring buffer bookkeeping: write/read pointers and fill level, updated when a
// burst commits. Also reports how many words remain before each pointer wraps.
module cyp_sdram_arbiter_ring_ptr
  import cyp_sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              commit_wr_i,
  input  logic              commit_rd_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   wr_to_wrap_o,
  output logic [ADDR_W:0]   rd_to_wrap_o
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BL    = (ADDR_W+1)'(BURST_LEN);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;

  // Pointer arithmetic wraps naturally at DEPTH; a full-DEPTH burst leaves the pointer unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (commit_wr_i) begin
      wr_ptr_d = wr_ptr_q + len_i[ADDR_W-1:0];
      level_d  = level_q + len_i;
    end else if (commit_rd_i) begin
      rd_ptr_d = rd_ptr_q + len_i[ADDR_W-1:0];
      level_d  = level_q - len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign level_o      = level_q;
  assign full_o       = (DEPTH - level_q) < BL;
  assign empty_o      = (level_q == '0);
  assign wr_to_wrap_o = DEPTH - {1'b0, wr_ptr_q};
  assign rd_to_wrap_o = DEPTH - {1'b0, rd_ptr_q};

endmodule

// File: rtl/cyp_sdram_arbiter.sv
// Round-robin burst scheduler sharing one SDRAM user port between the EP2->ring
// write path and the ring->EP6 read path. Define ARB_FLUSH_EN to flush partial bursts.
module cyp_sdram_arbiter
  import cyp_sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = 10,
  parameter int FLUSH_TMO = 1024
) (
  input  logic              sdram_clk,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic              wr_fifo_rempty,
  input  logic [CNT_W-1:0]  wr_fifo_rd_cnt,
  output logic              wr_fifo_ren,
  input  logic [DATA_W-1:0] wr_fifo_rdata,
  input  logic [CNT_W-1:0]  rd_fifo_wr_space,
  output logic              rd_fifo_wen,
  output logic [DATA_W-1:0] rd_fifo_wdata,
  output logic              sd_cmd_req,
  input  logic              sd_cmd_ack,
  output logic              sd_cmd_wr,
  output logic [ADDR_W-1:0] sd_cmd_addr,
  output logic [ADDR_W:0]   sd_cmd_len,
  input  logic              sd_wdata_req,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_rdata_vld,
  input  logic [DATA_W-1:0] sd_rdata,
  input  logic              sd_cmd_done,
  output logic [ADDR_W:0]   ring_level,
  output logic              ring_full,
  output logic              ring_empty,
  output logic              arb_busy
);

  localparam int LW = ADDR_W + 1;
  localparam int CW = (LW > CNT_W) ? LW : CNT_W;
  localparam logic [LW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LW-1:0] BL    = LW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > (2 ** ADDR_W) || FLUSH_TMO < 1) begin : g_bad_param
    $error("cyp_sdram_arbiter: BURST_LEN must be 1..2**ADDR_W and FLUSH_TMO >= 1");
  end

  function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  arb_state_e        state_q, state_d;
  grant_e            last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     len_q, len_d;
  logic              wr_q, wr_d;
  logic [LW-1:0]     wcnt_q, wcnt_d;
  logic              commit_wr, commit_rd;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]     level, wr_to_wrap, rd_to_wrap, room;

  cyp_sdram_arbiter_ring_ptr #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_ring (
    .clk_i        (sdram_clk),
    .rst_i        (rst),
    .commit_wr_i  (commit_wr),
    .commit_rd_i  (commit_rd),
    .len_i        (len_q),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .level_o      (level),
    .full_o       (ring_full),
    .empty_o      (ring_empty),
    .wr_to_wrap_o (wr_to_wrap),
    .rd_to_wrap_o (rd_to_wrap)
  );

  assign room = DEPTH - level;

  logic [CW-1:0] wr_avail, rd_avail, wlen, rlen;
  logic          wr_full_elig, rd_full_elig, wr_elig, rd_elig;
  logic          can_gnt, gnt_wr, gnt_rd;

  // The empty flag overrides a stale nonzero occupancy count.
  assign wr_avail     = wr_fifo_rempty ? '0 : min2(CW'(wr_fifo_rd_cnt), CW'(room));
  assign rd_avail     = min2(CW'(level), CW'(rd_fifo_wr_space));
  assign wlen         = min2(min2(wr_avail, CW'(BL)), CW'(wr_to_wrap));
  assign rlen         = min2(min2(rd_avail, CW'(BL)), CW'(rd_to_wrap));
  assign wr_full_elig = !wr_fifo_rempty && (CW'(wr_fifo_rd_cnt) >= CW'(BL)) && (room >= BL);
  assign rd_full_elig = (level >= BL) && (CW'(rd_fifo_wr_space) >= CW'(BL));

`ifdef ARB_FLUSH_EN
  localparam int TW = $clog2(FLUSH_TMO + 1);
  localparam logic [TW-1:0] TMO = TW'(FLUSH_TMO);

  logic [TW-1:0] wtmr_q, rtmr_q;
  logic          wr_hold, rd_hold;

  assign wr_hold = !wr_fifo_rempty;
  assign rd_hold = (level != '0);
  assign wr_elig = wr_full_elig || (wtmr_q == TMO && wr_avail != '0);
  assign rd_elig = rd_full_elig || (rtmr_q == TMO && rd_avail != '0);

  // Timers age only while idle with data stuck below a full burst; they saturate at TMO.
  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      wtmr_q <= '0;
      rtmr_q <= '0;
    end else begin
      if (gnt_wr) wtmr_q <= '0;
      else if (state_q == ST_IDLE) begin
        if (!wr_hold || wr_full_elig) wtmr_q <= '0;
        else if (wtmr_q != TMO)       wtmr_q <= wtmr_q + 1'b1;
      end
      if (gnt_rd) rtmr_q <= '0;
      else if (state_q == ST_IDLE) begin
        if (!rd_hold || rd_full_elig) rtmr_q <= '0;
        else if (rtmr_q != TMO)       rtmr_q <= rtmr_q + 1'b1;
      end
    end
  end
`else
  assign wr_elig = wr_full_elig;
  assign rd_elig = rd_full_elig;
`endif

  assign can_gnt = (state_q == ST_IDLE) && sdram_init_done;
  assign gnt_wr  = can_gnt && wr_elig && (!rd_elig || last_gnt_q == GNT_READ);
  assign gnt_rd  = can_gnt && rd_elig && !gnt_wr;

  assign wr_fifo_ren = (state_q == ST_WR_DAT) && sd_wdata_req && (wcnt_q != len_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_d       = wr_q;
    wcnt_d     = wcnt_q;
    commit_wr  = 1'b0;
    commit_rd  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_wr) begin
          state_d    = ST_WR_REQ;
          last_gnt_d = GNT_WRITE;
          addr_d     = wr_ptr;
          len_d      = LW'(wlen);
          wr_d       = SD_CMD_WR;
          wcnt_d     = '0;
        end else if (gnt_rd) begin
          state_d    = ST_RD_REQ;
          last_gnt_d = GNT_READ;
          addr_d     = rd_ptr;
          len_d      = LW'(rlen);
          wr_d       = SD_CMD_RD;
        end
      end
      ST_WR_REQ: if (sd_cmd_ack) state_d = ST_WR_DAT;
      ST_RD_REQ: if (sd_cmd_ack) state_d = ST_RD_DAT;
      ST_WR_DAT: begin
        if (wr_fifo_ren) wcnt_d = wcnt_q + 1'b1;
        if (sd_cmd_done) begin
          state_d   = ST_IDLE;
          commit_wr = 1'b1;
        end
      end
      ST_RD_DAT: begin
        if (sd_cmd_done) begin
          state_d   = ST_IDLE;
          commit_rd = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_READ;
      addr_q     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign sd_cmd_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign sd_cmd_wr     = wr_q;
  assign sd_cmd_addr   = addr_q;
  assign sd_cmd_len    = len_q;
  assign sd_wdata      = wr_fifo_rdata;
  assign rd_fifo_wen   = (state_q == ST_RD_DAT) && sd_rdata_vld;
  assign rd_fifo_wdata = rd_fifo_wen ? sd_rdata : '0;
  assign ring_level    = level;
  assign arb_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cyp_sdram_arbiter.sv
// Scoreboard bench for cyp_sdram_arbiter with a 1024-word ring, a write-FIFO model
// and a simple SDRAM controller model; the flush scenario follows ARB_FLUSH_EN.
module tb_cyp_sdram_arbiter;

  localparam int AW  = 10;
  localparam int BL  = 256;
  localparam int CW  = 10;
  localparam int TMO = 64;

  logic          sdram_clk = 1'b0;
  logic          rst;
  logic          sdram_init_done;
  logic          wr_fifo_rempty;
  logic [CW-1:0] wr_fifo_rd_cnt;
  logic          wr_fifo_ren;
  logic [15:0]   wr_fifo_rdata = '0;
  logic [CW-1:0] rd_fifo_wr_space;
  logic          rd_fifo_wen;
  logic [15:0]   rd_fifo_wdata;
  logic          sd_cmd_req, sd_cmd_ack, sd_cmd_wr;
  logic [AW-1:0] sd_cmd_addr;
  logic [AW:0]   sd_cmd_len;
  logic          sd_wdata_req;
  logic [15:0]   sd_wdata;
  logic          sd_rdata_vld;
  logic [15:0]   sd_rdata;
  logic          sd_cmd_done;
  logic [AW:0]   ring_level;
  logic          ring_full, ring_empty, arb_busy;

  always #5 sdram_clk = ~sdram_clk;

  cyp_sdram_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .CNT_W(CW), .FLUSH_TMO(TMO)) dut (
    .sdram_clk(sdram_clk), .rst(rst), .sdram_init_done(sdram_init_done),
    .wr_fifo_rempty(wr_fifo_rempty), .wr_fifo_rd_cnt(wr_fifo_rd_cnt),
    .wr_fifo_ren(wr_fifo_ren), .wr_fifo_rdata(wr_fifo_rdata),
    .rd_fifo_wr_space(rd_fifo_wr_space), .rd_fifo_wen(rd_fifo_wen),
    .rd_fifo_wdata(rd_fifo_wdata), .sd_cmd_req(sd_cmd_req), .sd_cmd_ack(sd_cmd_ack),
    .sd_cmd_wr(sd_cmd_wr), .sd_cmd_addr(sd_cmd_addr), .sd_cmd_len(sd_cmd_len),
    .sd_wdata_req(sd_wdata_req), .sd_wdata(sd_wdata), .sd_rdata_vld(sd_rdata_vld),
    .sd_rdata(sd_rdata), .sd_cmd_done(sd_cmd_done), .ring_level(ring_level),
    .ring_full(ring_full), .ring_empty(ring_empty), .arb_busy(arb_busy)
  );

  typedef struct { bit wr; int addr; int len; } cmd_t;

  cmd_t        exp_cmd[$];
  logic [15:0] exp_wd[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [0:1023];

  int  checks = 0;
  int  errors = 0;
  int  wpushed = 0;
  int  wpopped = 0;
  int  ren_total = 0;
  int  wen_total = 0;
  bit  abort = 1'b0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Write FIFO model: word value equals its sequence number; data appears one cycle after ren.
  assign wr_fifo_rd_cnt = ((wpushed - wpopped) > 1023) ? 10'd1023 : 10'(wpushed - wpopped);
  assign wr_fifo_rempty = (wpushed == wpopped);
  always @(posedge sdram_clk) begin
    if (wr_fifo_ren) begin
      wr_fifo_rdata <= 16'(wpopped);
      wpopped       <= wpopped + 1;
    end
  end

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_wd.push_back(16'(wpushed + i));
    wpushed = wpushed + n;
  endtask

  task automatic push_cmd(input bit w, input int a, input int l);
    cmd_t c;
    c.wr = w; c.addr = a; c.len = l;
    exp_cmd.push_back(c);
  endtask

  task automatic push_rd(input int first, input int n);
    for (int i = 0; i < n; i++) exp_rd.push_back(16'(first + i));
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (!sd_cmd_req && n < max) begin
      step();
      n++;
    end
    if (!sd_cmd_req) chk("req_timeout", sd_cmd_req, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (arb_busy && n < 3000) begin
      step();
      n++;
    end
    if (arb_busy) chk("busy_timeout", arb_busy, 0);
  endtask

  // SDRAM controller model
  initial begin
    int ca, cl;
    bit cw;
    sd_cmd_ack = 0; sd_wdata_req = 0; sd_rdata_vld = 0; sd_rdata = '0; sd_cmd_done = 0;
    forever begin
      step();
      if (sd_cmd_req && !abort) begin
        ca = int'(sd_cmd_addr);
        cl = int'(sd_cmd_len);
        cw = sd_cmd_wr;
        repeat (2) step();
        if (!abort) begin
          sd_cmd_ack = 1; step(); sd_cmd_ack = 0;
        end
        if (cw) begin
          for (int i = 0; i < cl + 2 && !abort; i++) begin
            sd_wdata_req = 1; step();
          end
          sd_wdata_req = 0;
          repeat (2) step();
        end else begin
          for (int i = 0; i < cl && !abort; i++) begin
            sd_rdata_vld = 1; sd_rdata = mem[(ca + i) % 1024]; step();
          end
          sd_rdata_vld = 0; sd_rdata = '0;
        end
        if (!abort) begin
          sd_cmd_done = 1; step(); sd_cmd_done = 0;
        end
      end
    end
  end

  // Monitor: compares every command, every written word and every read-FIFO push
  initial begin
    bit prev_req, wd_pend;
    int wa;
    cmd_t c;
    logic [15:0] e;
    prev_req = 0; wd_pend = 0; wa = 0;
    forever begin
      @(negedge sdram_clk);
      if (wd_pend) begin
        if (exp_wd.size() == 0) chk("wdata_unexpected", 1, 0);
        else begin
          e = exp_wd.pop_front();
          chk("sd_wdata", sd_wdata, e);
        end
        mem[wa] = sd_wdata;
        wa = (wa + 1) % 1024;
      end
      wd_pend = wr_fifo_ren;
      if (wr_fifo_ren) ren_total++;
      if (sd_cmd_req && !prev_req) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          c = exp_cmd.pop_front();
          chk("cmd_wr", sd_cmd_wr, c.wr);
          chk("cmd_addr", sd_cmd_addr, c.addr);
          chk("cmd_len", sd_cmd_len, c.len);
        end
        if (sd_cmd_wr) wa = int'(sd_cmd_addr);
      end
      prev_req = sd_cmd_req;
      if (rd_fifo_wen) begin
        wen_total++;
        if (exp_rd.size() == 0) chk("rdata_unexpected", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_fifo_wdata", rd_fifo_wdata, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, t0;
    rst = 1; sdram_init_done = 0; rd_fifo_wr_space = '0;
    repeat (3) step();
    @(negedge sdram_clk);
    chk("rst_cmd_req", sd_cmd_req, 0);
    chk("rst_cmd_wr", sd_cmd_wr, 0);
    chk("rst_cmd_addr", sd_cmd_addr, 0);
    chk("rst_cmd_len", sd_cmd_len, 0);
    chk("rst_ren", wr_fifo_ren, 0);
    chk("rst_wen", rd_fifo_wen, 0);
    chk("rst_level", ring_level, 0);
    chk("rst_empty", ring_empty, 1);
    chk("rst_full", ring_full, 0);
    chk("rst_busy", arb_busy, 0);
    step();
    rst = 0;

    // No request before init; first grant is a write
    push_words(300);
    push_cmd(1, 0, 256);
    cnt = 0;
    repeat (20) begin step(); if (sd_cmd_req) cnt++; end
    chk("req_before_init", cnt, 0);
    sdram_init_done = 1;
    wait_req(3, n);
    chk("req_latency_le2", (n <= 2), 1);
    t0 = ren_total;
    wait_idle();
    chk("wr_burst_pops", ren_total - t0, 256);
    chk("level_after_wr", ring_level, 256);

    // Both eligible after a write grant: read wins
    push_cmd(0, 0, 256);
    push_rd(0, 256);
    push_cmd(1, 256, 256);
    push_words(256);
    rd_fifo_wr_space = 10'd300;
    t0 = wen_total;
    wait_req(10, n);
    rd_fifo_wr_space = '0;
    wait_idle();
    chk("rd_wen_count", wen_total - t0, 256);
    chk("level_after_rd", ring_level, 0);
    wait_req(10, n);
    wait_idle();
    chk("level_after_wr2", ring_level, 256);

    // Fill ring to full, wrapping the write pointer
    push_cmd(1, 512, 256);
    push_cmd(1, 768, 256);
    push_cmd(1, 0, 256);
    push_words(1024);
    repeat (3) begin
      wait_req(20, n);
      wait_idle();
    end
    chk("level_full", ring_level, 1024);
    chk("ring_full", ring_full, 1);
    cnt = 0;
    repeat (50) begin step(); if (sd_cmd_req) cnt++; end
    chk("no_grant_when_full", cnt, 0);
    push_cmd(0, 256, 256);
    push_rd(256, 256);
    push_cmd(1, 256, 256);
    rd_fifo_wr_space = 10'd256;
    wait_req(20, n);
    rd_fifo_wr_space = '0;
    wait_idle();
    chk("level_after_rd2", ring_level, 768);
    wait_req(20, n);
    wait_idle();
    chk("level_refull", ring_level, 1024);

    // Reset in the middle of a write data phase
    rst = 1; step(); rst = 0;
    chk("level_after_rst", ring_level, 0);
    push_cmd(1, 0, 256);
    push_cmd(1, 0, 256);
    push_words(512);
    wait_req(20, n);
    n = 0;
    while (sd_cmd_req && n < 50) begin step(); n++; end
    repeat (100) step();
    abort = 1;
    rst = 1;
    @(negedge sdram_clk);
    chk("mid_rst_req", sd_cmd_req, 0);
    chk("mid_rst_ren", wr_fifo_ren, 0);
    chk("mid_rst_len", sd_cmd_len, 0);
    chk("mid_rst_wr", sd_cmd_wr, 0);
    chk("mid_rst_level", ring_level, 0);
    chk("mid_rst_busy", arb_busy, 0);
    step();
    rst = 0;
    step();
    abort = 0;
    wait_req(20, n);
    wait_idle();
    chk("level_regrant", ring_level, 256);

    // Top write FIFO up to exactly one burst, leaving it empty afterwards
    n = wpushed - wpopped;
    push_cmd(1, 256, 256);
    push_words(256 - n);
    wait_req(20, n);
    wait_idle();
    chk("level_topup", ring_level, 512);
    chk("fifo_drained", wr_fifo_rempty, 1);

    // Short transfer: flushed after the idle timeout, or held indefinitely
    push_words(10);
`ifdef ARB_FLUSH_EN
    push_cmd(1, 512, 10);
    wait_req(200, n);
    chk("flush_delay_in_window", (n >= 60 && n <= 70), 1);
    wait_idle();
    chk("level_after_flush", ring_level, 522);
`else
    cnt = 0;
    repeat (1000) begin step(); if (sd_cmd_req) cnt++; end
    chk("no_partial_burst", cnt, 0);
    chk("level_no_flush", ring_level, 512);
`endif

    repeat (5) step();
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("wd_queue_matches_fifo", exp_wd.size(), wpushed - wpopped);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
